nx_fifo_packer: RTL and testbench
=================================

NX_FIFO_PACKER -- requirements
Module: nx_fifo_packer

Interface
REQ-001 SHALL have parameter NIB_W, default 4: width of one FIFO entry (nibble), equal to upstream nx_fifo wdata/rdata width.
REQ-002 SHALL have parameter NIBS, default 4: nibbles per output word; 2..8.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port fifo_empty, input, 1: upstream FIFO empty flag.
REQ-006 SHALL have port fifo_rdata, input, NIB_W: upstream show-ahead head entry, valid in the same cycle whenever fifo_empty=0.
REQ-007 SHALL have port fifo_ren, output, 1: pop strobe to the upstream FIFO ren.
REQ-008 SHALL have port flush, input, 1: single-cycle request to emit a partial word.
REQ-009 SHALL have port out_valid, output, 1: output word valid.
REQ-010 SHALL have port out_ready, input, 1: downstream accept.
REQ-011 SHALL have port out_data, output, NIBS*NIB_W: packed word.
REQ-012 SHALL have port out_cnt, output, clog2(NIBS+1): count of valid nibbles in out_data, 1..NIBS.
REQ-013 SHALL have port flush_done, output, 1: one-cycle pulse when a flush completes.
REQ-014 SHALL have port word_count, output, 8: count of accepted output words, wrapping at 255->0.

Function
REQ-015 SHALL hold internal accumulator acc (NIBS*NIB_W), fill count cnt (0..NIBS) and sticky flag flush_pend.
REQ-016 SHALL define drain = out_valid & out_ready and slot_free = ~out_valid | drain.
REQ-017 SHALL define xfer = slot_free & (cnt==NIBS | (flush_pend & cnt!=0)).
REQ-018 SHALL drive fifo_ren = ~fifo_empty & ~flush_pend & (cnt<NIBS | xfer), combinationally; fifo_ren SHALL never assert while fifo_empty=1.
REQ-019 On a pop, SHALL write fifo_rdata to acc slot cnt, using slot 0 if xfer is also true; the first nibble occupies bits [NIB_W-1:0] (little-endian).
REQ-020 On xfer, SHALL load out_data<=acc, out_cnt<=cnt and out_valid<=1, and SHALL clear acc to 0 and set cnt to 0, or to 1 if a pop occurs in the same cycle.
REQ-021 Unused upper slots of a partial word SHALL read 0.
REQ-022 On drain without xfer, SHALL set out_valid<=0; out_data and out_cnt SHALL hold their values.
REQ-023 While out_valid=1 and out_ready=0, out_data and out_cnt SHALL be stable.
REQ-024 Latency: the word SHALL appear (out_valid=1) 2 cycles after the cycle that pops its last nibble, given a free slot.
REQ-025 Throughput: sustained input SHALL produce 1 word per NIBS cycles with out_ready=1.
REQ-026 flush=1 SHALL set flush_pend; a flush arriving while flush_pend=1 SHALL be absorbed.
REQ-027 While flush_pend=1, no pops SHALL occur.
REQ-028 With flush_pend=1 and cnt==0, the block SHALL clear flush_pend next cycle, pulse flush_done and emit no word.
REQ-029 With flush_pend=1 and cnt>0, flush_pend SHALL clear on xfer, and flush_done SHALL pulse in the cycle after xfer.
REQ-030 word_count SHALL increment on each drain.
REQ-031 The operating state SHALL be one of FILL (cnt<NIBS, ~flush_pend), WAIT (cnt==NIBS, ~xfer) or FLUSH (flush_pend).
REQ-032 WAIT SHALL persist while out_valid & ~out_ready.

Reset
REQ-033 On rst=1 at a clock edge, the block SHALL set out_valid=0, out_data=0, out_cnt=0, flush_done=0, word_count=0, acc=0, cnt=0 and flush_pend=0.
REQ-034 fifo_ren SHALL be 0 in any cycle where rst=1.
REQ-035 Reset mid-word SHALL discard the partial accumulator and any held output word.

Verification
REQ-036 Upstream supplies 1,2,3,4 on consecutive cycles, out_ready=1 -> out_data=0x4321, out_cnt=4, out_valid=1 for one cycle, 2 cycles after the pop of 4.
REQ-037 8 nibbles 0..7 back-to-back with out_ready=0 until cycle 10 -> first word 0x3210 held stable, fifo_ren=0 once cnt=4; after release, second word 0x7654 follows, and word_count=2.
REQ-038 Push A,B then flush -> out_data=0x00BA, out_cnt=2, flush_done pulses, and no pops occur while flush_pend=1.
REQ-039 Flush with cnt=0 -> no out_valid, flush_done pulses one cycle later.
REQ-040 rst asserted after 3 nibbles with an output word pending -> all outputs 0 next cycle; subsequent nibbles 5,6,7,8 -> 0x8765.
REQ-041 Random fifo_empty/out_ready for 10k cycles -> scoreboard nibble order exact, no pop while fifo_empty=1, and word_count equals accepted words mod 256.

Source files
------------

// File: rtl/nx_fifo_packer.sv
// nx_fifo_packer: packs NIB_W-bit entries popped from a show-ahead FIFO into
// NIBS-entry output words, little-endian (first entry in the low bits).
// A single-cycle flush request emits any partial word with zeroed upper slots.
//
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   fifo_empty   - upstream FIFO empty flag
//   fifo_rdata   - upstream show-ahead head entry
//   fifo_ren     - pop strobe to the upstream FIFO (combinational)
//   flush        - request to emit a partial word
//   out_valid    - output word valid
//   out_ready    - downstream accept
//   out_data     - packed word
//   out_cnt      - number of valid entries in out_data (1..NIBS)
//   flush_done   - one-cycle pulse when a flush completes
//   word_count   - accepted output words, wraps at 255
module nx_fifo_packer #(
    parameter int unsigned NIB_W = 4,
    parameter int unsigned NIBS  = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             fifo_empty,
    input  logic [NIB_W-1:0]                 fifo_rdata,
    output logic                             fifo_ren,
    input  logic                             flush,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NIBS*NIB_W-1:0]            out_data,
    output logic [$clog2(NIBS+1)-1:0]        out_cnt,
    output logic                             flush_done,
    output logic [7:0]                       word_count
);

    localparam int unsigned CntW  = $clog2(NIBS + 1);
    localparam int unsigned WordW = NIBS * NIB_W;

    logic [WordW-1:0] acc_q, acc_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             flush_pend_q, flush_pend_d;
    logic             out_valid_q, out_valid_d;
    logic [WordW-1:0] out_data_q, out_data_d;
    logic [CntW-1:0]  out_cnt_q, out_cnt_d;
    logic             flush_done_q, flush_done_d;
    logic [7:0]       word_count_q;

    logic            full;
    logic            drain;
    logic            slot_free;
    logic            xfer;
    logic            pop;
    logic [CntW-1:0] wr_slot;

    assign full      = (cnt_q == CntW'(NIBS));
    assign drain     = out_valid_q & out_ready;
    assign slot_free = ~out_valid_q | drain;
    assign xfer      = slot_free & (full | (flush_pend_q & (cnt_q != '0)));
    // A full accumulator may still pop when it is being emitted this cycle.
    assign pop       = ~rst & ~fifo_empty & ~flush_pend_q & (~full | xfer);
    // An entry popped alongside an emit starts the next word.
    assign wr_slot   = xfer ? '0 : cnt_q;

    always_comb begin
        acc_d = xfer ? '0 : acc_q;
        for (int unsigned i = 0; i < NIBS; i++) begin
            if (pop && (wr_slot == CntW'(i))) begin
                acc_d[i*NIB_W +: NIB_W] = fifo_rdata;
            end
        end
    end

    always_comb begin
        cnt_d = xfer ? '0 : cnt_q;
        if (pop) begin
            cnt_d = cnt_d + CntW'(1);
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_cnt_d   = out_cnt_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = acc_q;
            out_cnt_d   = cnt_q;
        end else if (drain) begin
            out_valid_d = 1'b0;
        end
    end

    // Flush completes either immediately (nothing buffered) or on the emit of
    // the partial word; further flush requests meanwhile are absorbed.
    always_comb begin
        flush_done_d = flush_pend_q & ((cnt_q == '0) | xfer);
        if (flush_pend_q) begin
            flush_pend_d = ~flush_done_d;
        end else begin
            flush_pend_d = flush;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_cnt_q    <= '0;
            flush_done_q <= 1'b0;
            word_count_q <= 8'd0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_cnt_q    <= out_cnt_d;
            flush_done_q <= flush_done_d;
            word_count_q <= word_count_q + {7'd0, drain};
        end
    end

    assign fifo_ren   = pop;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_cnt    = out_cnt_q;
    assign flush_done = flush_done_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_nx_fifo_packer.sv
// Bench for nx_fifo_packer: directed scenarios with literal expectations plus
// a queue-based reference model compared every cycle, and a random phase
// with an end-to-end nibble-order scoreboard.
module tb_nx_fifo_packer;

    localparam int NIBS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_empty;
    logic [3:0]  fifo_rdata;
    logic        fifo_ren;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [2:0]  out_cnt;
    logic        flush_done;
    logic [7:0]  word_count;

    nx_fifo_packer #(
        .NIB_W(4),
        .NIBS (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_ren   (fifo_ren),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_cnt    (out_cnt),
        .flush_done (flush_done),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Upstream show-ahead FIFO model.
    logic [3:0]  up_mem [16384];
    logic [13:0] up_rd;
    logic [13:0] up_wr = 14'd0;
    logic        hold_empty;

    assign fifo_empty = hold_empty || (up_rd == up_wr);
    assign fifo_rdata = up_mem[up_rd];

    always @(posedge clk) begin
        if (rst) up_rd <= up_wr;
        else if (fifo_ren) up_rd <= up_rd + 14'd1;
    end

    task automatic push(input logic [3:0] v);
        up_mem[up_wr] = v;
        up_wr = up_wr + 14'd1;
    endtask

    // Reference model state.
    logic [3:0]  m_acc [$];
    logic        m_valid = 1'b0;
    logic [15:0] m_data  = 16'd0;
    logic [2:0]  m_cnt   = 3'd0;
    logic        m_pend  = 1'b0;
    logic        m_done  = 1'b0;
    logic [7:0]  m_wc    = 8'd0;
    logic        m_live  = 1'b0;

    logic        sb_on = 1'b0;
    logic [13:0] sb_ptr = 14'd0;
    int          accepted = 0;

    // Compare at the falling edge, then advance the model to the state the
    // next rising edge must produce.
    always @(negedge clk) begin
        int   sz;
        logic m_full, m_drain, m_free, m_xfer, m_ren;
        if (m_live) begin
            chk("out_valid", out_valid, m_valid);
            if (m_valid) begin
                chk("out_data", out_data, m_data);
                chk("out_cnt", out_cnt, m_cnt);
            end
            chk("flush_done", flush_done, m_done);
            chk("word_count", word_count, m_wc);
        end
        chk("pop_on_empty", fifo_ren & fifo_empty, 0);

        sz      = m_acc.size();
        m_full  = (sz == NIBS);
        m_drain = m_valid & out_ready;
        m_free  = !m_valid | m_drain;
        m_xfer  = m_free & (m_full | (m_pend & (sz != 0)));
        m_ren   = !rst & !fifo_empty & !m_pend & (!m_full | m_xfer);
        if (m_live || rst) chk("fifo_ren", fifo_ren, m_ren);

        if (sb_on && out_valid && out_ready) begin
            accepted++;
            for (int i = 0; i < int'(out_cnt); i++) begin
                chk("sb_nibble", out_data[i*4 +: 4], up_mem[sb_ptr]);
                sb_ptr = sb_ptr + 14'd1;
            end
        end

        if (rst) begin
            m_acc.delete();
            m_valid = 1'b0;
            m_data  = 16'd0;
            m_cnt   = 3'd0;
            m_pend  = 1'b0;
            m_done  = 1'b0;
            m_wc    = 8'd0;
            m_live  = 1'b1;
        end else begin
            m_done = m_pend & ((sz == 0) | m_xfer);
            m_wc   = m_wc + 8'(m_drain);
            if (m_pend) m_pend = !m_done;
            else m_pend = flush;
            if (m_xfer) begin
                m_data = 16'd0;
                foreach (m_acc[i]) m_data[i*4 +: 4] = m_acc[i];
                m_cnt   = 3'(sz);
                m_valid = 1'b1;
                m_acc.delete();
            end else if (m_drain) begin
                m_valid = 1'b0;
            end
            if (m_ren) m_acc.push_back(fifo_rdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at the start of cycle 0 (just after a rising edge).
    task automatic do_reset();
        rst        = 1'b1;
        flush      = 1'b0;
        hold_empty = 1'b0;
        out_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst        = 1'b1;
        flush      = 1'b0;
        hold_empty = 1'b0;
        out_ready  = 1'b0;

        // Two back-to-back words at full rate.
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push(4'(i));
        repeat (6) @(negedge clk);  // cycle 5
        chk("t1_valid", out_valid, 1);
        chk("t1_data", out_data, 16'h4321);
        chk("t1_cnt", out_cnt, 4);
        @(negedge clk);             // cycle 6
        chk("t1_gap", out_valid, 0);
        chk("t1_wc", word_count, 1);
        repeat (3) @(negedge clk);  // cycle 9
        chk("t1_valid2", out_valid, 1);
        chk("t1_data2", out_data, 16'h8765);
        @(negedge clk);
        chk("t1_wc2", word_count, 2);

        // Backpressure: first word held, pops stop once the accumulator is full.
        do_reset();
        for (int i = 0; i <= 8; i++) push(4'(i));
        repeat (6) @(negedge clk);  // cycle 5
        chk("t2_valid", out_valid, 1);
        chk("t2_data", out_data, 16'h3210);
        repeat (4) @(negedge clk);  // cycle 9
        chk("t2_hold_ren", fifo_ren, 0);
        chk("t2_hold_valid", out_valid, 1);
        chk("t2_hold_data", out_data, 16'h3210);
        chk("t2_hold_cnt", out_cnt, 4);
        tick();                     // cycle 10
        out_ready = 1'b1;
        @(negedge clk);
        chk("t2_rel_data", out_data, 16'h3210);
        @(negedge clk);             // cycle 11
        chk("t2_valid2", out_valid, 1);
        chk("t2_data2", out_data, 16'h7654);
        chk("t2_cnt2", out_cnt, 4);
        @(negedge clk);             // cycle 12
        chk("t2_wc", word_count, 2);
        chk("t2_idle", out_valid, 0);

        // Partial word flush.
        do_reset();
        out_ready = 1'b1;
        push(4'hA);
        push(4'hB);
        tick();
        tick();                     // cycle 2
        flush = 1'b1;
        tick();                     // cycle 3
        flush = 1'b0;
        push(4'hC);
        @(negedge clk);
        chk("t3_no_pop", fifo_ren, 0);
        @(negedge clk);             // cycle 4
        chk("t3_valid", out_valid, 1);
        chk("t3_data", out_data, 16'h00BA);
        chk("t3_cnt", out_cnt, 2);
        chk("t3_done", flush_done, 1);
        @(negedge clk);
        chk("t3_done_end", flush_done, 0);

        // Flush with nothing buffered.
        do_reset();
        flush = 1'b1;
        tick();                     // cycle 1
        flush = 1'b0;
        @(negedge clk);
        chk("t4_done_early", flush_done, 0);
        @(negedge clk);             // cycle 2
        chk("t4_done", flush_done, 1);
        chk("t4_no_word", out_valid, 0);
        @(negedge clk);
        chk("t4_done_end", flush_done, 0);
        chk("t4_no_word2", out_valid, 0);

        // Reset with a held word and a partial accumulator.
        do_reset();
        push(4'h1); push(4'h2); push(4'h3); push(4'h4);
        push(4'h9); push(4'h9); push(4'h9);
        repeat (8) @(negedge clk);  // cycle 7
        chk("t5_pending", out_valid, 1);
        tick();                     // cycle 8
        rst = 1'b1;
        push(4'h9);
        @(negedge clk);
        chk("t5_ren_in_rst", fifo_ren, 0);
        tick();                     // cycle 9
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t5_valid0", out_valid, 0);
        chk("t5_data0", out_data, 0);
        chk("t5_cnt0", out_cnt, 0);
        chk("t5_wc0", word_count, 0);
        chk("t5_done0", flush_done, 0);
        tick();
        push(4'h5); push(4'h6); push(4'h7); push(4'h8);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        chk("t5_timeout", n < 20, 1);
        chk("t5_data", out_data, 16'h8765);
        chk("t5_cnt", out_cnt, 4);

        // Random traffic with scoreboard.
        tick();
        do_reset();
        sb_ptr   = up_wr;
        accepted = 0;
        sb_on    = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            hold_empty = ($urandom_range(0, 3) == 0);
            out_ready  = ($urandom_range(0, 2) != 0);
            flush      = ($urandom_range(0, 40) == 0);
            if (14'(up_wr - up_rd) < 14'd6 && $urandom_range(0, 1) == 1) begin
                push(4'($urandom_range(0, 15)));
            end
            tick();
        end
        flush      = 1'b0;
        hold_empty = 1'b0;
        out_ready  = 1'b1;
        repeat (12) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (20) tick();
        @(negedge clk);
        chk("t6_all_out", sb_ptr, up_wr);
        chk("t6_wc", word_count, 8'(accepted));
        chk("t6_some_words", accepted > 100, 1);
        sb_on = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
